lfsr_period_monitor: RTL and testbench

//  Downstream checker for the 4-bit LFSR stage. Samples the LFSR state on each step strobe.

---
 rtl/lfsr_pkg.sv | 22 ++
 rtl/lfsr_period_monitor.sv | 150 +++++++++++++++
 tb/tb_lfsr_period_monitor.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// ============================================================================
// Module : lfsr_pkg
// Brief  : Shared LFSR constants and period-monitor FSM state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lfsr_pkg;

    localparam int LFSR_W          = 4;
    localparam int LFSR_MAX_PERIOD = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } mon_state_t;

endpackage

`default_nettype wire

// File: rtl/lfsr_period_monitor.sv
// ============================================================================
// Module : lfsr_period_monitor
// Brief  : Measures LFSR sequence period from step-strobed samples; flags
//          all-zero lockup and runaway (timeout). Optional ones_cnt balance
//          counter enabled by `define LFSR_ONES_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lfsr_period_monitor
    import lfsr_pkg::*;
#(
    parameter int WIDTH     = LFSR_W,
    parameter int CNT_W     = 5,
    parameter int MAX_STEPS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] state_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period,
    output logic             lockup,
    output logic             timeout
`ifdef LFSR_ONES_CNT_EN
    ,
    output logic [CNT_W-1:0] ones_cnt
`endif
);

    mon_state_t       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_ref, w_ref_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_period, w_period_nxt;
    logic             r_lockup, w_lockup_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic             r_busy, r_done;
    logic [CNT_W-1:0] w_n;
    logic             w_zero, w_match;
`ifdef LFSR_ONES_CNT_EN
    logic [CNT_W-1:0] r_ones, w_ones_nxt;
    logic [CNT_W-1:0] w_bit0;
    assign w_bit0 = {{(CNT_W-1){1'b0}}, state_in[0]};
`endif

    assign w_n     = r_cnt + 1'b1;
    assign w_zero  = (state_in == '0);
    assign w_match = (state_in == r_ref);

    always_comb begin
        w_state_nxt   = r_state;
        w_ref_nxt     = r_ref;
        w_cnt_nxt     = r_cnt;
        w_period_nxt  = r_period;
        w_lockup_nxt  = r_lockup;
        w_timeout_nxt = r_timeout;
`ifdef LFSR_ONES_CNT_EN
        w_ones_nxt    = r_ones;
`endif
        // start from any state (re)arms with cleared results; it masks a coincident step
        if (start) begin
            w_state_nxt   = ARM;
            w_cnt_nxt     = '0;
            w_period_nxt  = '0;
            w_lockup_nxt  = 1'b0;
            w_timeout_nxt = 1'b0;
`ifdef LFSR_ONES_CNT_EN
            w_ones_nxt    = '0;
`endif
        end else if (step) begin
            case (r_state)
                ARM: begin
                    w_ref_nxt = state_in;
                    w_cnt_nxt = '0;
                    if (w_zero) begin
                        w_state_nxt  = DONE;
                        w_lockup_nxt = 1'b1;
                    end else begin
                        w_state_nxt = COUNT;
`ifdef LFSR_ONES_CNT_EN
                        w_ones_nxt  = w_bit0;
`endif
                    end
                end
                COUNT: begin
                    w_cnt_nxt = w_n;
                    if (w_match) begin
                        w_state_nxt  = DONE;
                        w_period_nxt = w_n;
                    end else if (w_zero) begin
                        w_state_nxt  = DONE;
                        w_lockup_nxt = 1'b1;
                        w_period_nxt = w_n;
                    end else if (w_n == CNT_W'(MAX_STEPS)) begin
                        w_state_nxt   = DONE;
                        w_timeout_nxt = 1'b1;
                        w_period_nxt  = w_n;
                    end else begin
`ifdef LFSR_ONES_CNT_EN
                        w_ones_nxt = r_ones + w_bit0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_ref     <= '0;
            r_cnt     <= '0;
            r_period  <= '0;
            r_lockup  <= 1'b0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef LFSR_ONES_CNT_EN
            r_ones    <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_ref     <= w_ref_nxt;
            r_cnt     <= w_cnt_nxt;
            r_period  <= w_period_nxt;
            r_lockup  <= w_lockup_nxt;
            r_timeout <= w_timeout_nxt;
            r_busy    <= (w_state_nxt == ARM) || (w_state_nxt == COUNT);
            r_done    <= (w_state_nxt == DONE);
`ifdef LFSR_ONES_CNT_EN
            r_ones    <= w_ones_nxt;
`endif
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign period  = r_period;
    assign lockup  = r_lockup;
    assign timeout = r_timeout;
`ifdef LFSR_ONES_CNT_EN
    assign ones_cnt = r_ones;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lfsr_period_monitor.sv
// ============================================================================
// Module : tb_lfsr_period_monitor
// Brief  : Scenario-task bench with expected-result scoreboard queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lfsr_period_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       step = 1'b0;
    logic [3:0] state_in = 4'd0;
    logic       busy, done, lockup, timeout;
    logic [4:0] period;
`ifdef LFSR_ONES_CNT_EN
    logic [4:0] ones_cnt;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0] period;
        logic       lockup;
        logic       timeout;
        logic [4:0] ones;
        bit         chk_ones;
    } exp_t;

    exp_t sb[$];

    lfsr_period_monitor dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .step     (step),
        .state_in (state_in),
        .busy     (busy),
        .done     (done),
        .period   (period),
        .lockup   (lockup),
        .timeout  (timeout)
`ifdef LFSR_ONES_CNT_EN
        ,
        .ones_cnt (ones_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] lfsr_next(input logic [3:0] s);
        return {s[0] ^ s[1], s[3:1]};
    endfunction

    task automatic push_exp(input logic [4:0] p, input logic l, input logic t,
                            input logic [4:0] o, input bit co);
        exp_t e;
        e.period = p; e.lockup = l; e.timeout = t; e.ones = o; e.chk_ones = co;
        sb.push_back(e);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic do_step(input logic [3:0] s);
        @(negedge clk); step = 1'b1; state_in = s;
        @(negedge clk); step = 1'b0;
    endtask

    // Waits (bounded) for done, then pops and compares the oldest expectation.
    task automatic check_result(input string name);
        exp_t e;
        int   k;
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s done: got %b want 1 (wait expired)", name, done);
        end
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got empty want entry", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (period !== e.period) begin
            errors++;
            $display("FAIL %s period: got %0d want %0d", name, period, e.period);
        end
        checks++;
        if (lockup !== e.lockup) begin
            errors++;
            $display("FAIL %s lockup: got %b want %b", name, lockup, e.lockup);
        end
        checks++;
        if (timeout !== e.timeout) begin
            errors++;
            $display("FAIL %s timeout: got %b want %b", name, timeout, e.timeout);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy: got %b want 0", name, busy);
        end
`ifdef LFSR_ONES_CNT_EN
        if (e.chk_ones) begin
            checks++;
            if (ones_cnt !== e.ones) begin
                errors++;
                $display("FAIL %s ones_cnt: got %0d want %0d", name, ones_cnt, e.ones);
            end
        end
`endif
    endtask

    task automatic run_lfsr(input logic [3:0] seed, input int n);
        logic [3:0] s;
        s = seed;
        for (int i = 0; i < n; i++) begin
            do_step(s);
            s = lfsr_next(s);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, lockup, timeout} !== 4'b0000 || period !== 5'd0) begin
            errors++;
            $display("FAIL reset: got busy=%b done=%b lock=%b to=%b per=%0d want all 0",
                     busy, done, lockup, timeout, period);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_max_period();
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL armed_busy: got %b want 1", busy);
        end
        push_exp(5'd15, 1'b0, 1'b0, 5'd8, 1'b1);
        run_lfsr(4'b1000, 16);
        check_result("max_period");
        // A step while DONE must leave results untouched.
        do_step(4'b0000);
        checks++;
        if (done !== 1'b1 || period !== 5'd15 || lockup !== 1'b0) begin
            errors++;
            $display("FAIL done_hold: got done=%b per=%0d lock=%b want 1 15 0",
                     done, period, lockup);
        end
    endtask

    task automatic test_lockup();
        pulse_start();
        push_exp(5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        do_step(4'b0000);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL lockup_latency: got done=%b want 1", done);
        end
        check_result("lockup");
    endtask

    task automatic test_timeout();
        pulse_start();
        push_exp(5'd16, 1'b0, 1'b1, 5'd0, 1'b0);
        for (int i = 1; i <= 15; i++) do_step(4'(i));
        do_step(4'd2);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: got done=%b busy=%b want 0 1", done, busy);
        end
        do_step(4'd3);
        check_result("timeout");
    endtask

    task automatic test_back_to_back();
        pulse_start();
        push_exp(5'd1, 1'b0, 1'b0, 5'd1, 1'b1);
        do_step(4'd5);
        do_step(4'd5);
        check_result("short_p1");
        pulse_start();
        checks++;
        if (done !== 1'b0 || period !== 5'd0) begin
            errors++;
            $display("FAIL restart_clear: got done=%b per=%0d want 0 0", done, period);
        end
        push_exp(5'd2, 1'b0, 1'b0, 5'd2, 1'b1);
        do_step(4'd9);
        do_step(4'd3);
        do_step(4'd9);
        check_result("short_p2");
    endtask

    task automatic test_restart_mid_count();
        logic [3:0] s;
        pulse_start();
        s = 4'b1000;
        for (int i = 0; i < 7; i++) begin
            do_step(s);
            s = lfsr_next(s);
        end
        @(negedge clk); start = 1'b1; step = 1'b1; state_in = 4'b1000;
        @(negedge clk); start = 1'b0; step = 1'b0;
        checks++;
        if (busy !== 1'b1 || period !== 5'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL restart_mid: got busy=%b per=%0d done=%b want 1 0 0",
                     busy, period, done);
        end
        push_exp(5'd15, 1'b0, 1'b0, 5'd8, 1'b1);
        run_lfsr(4'b0110, 16);
        check_result("restart_full");
    endtask

    task automatic test_async_reset();
        pulse_start();
        run_lfsr(4'b1000, 5);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || period !== 5'd0) begin
            errors++;
            $display("FAIL async_rst: got busy=%b done=%b per=%0d want 0 0 0",
                     busy, done, period);
        end
        @(negedge clk); rst = 1'b1;
        do_step(4'b1000);
        do_step(4'b0100);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_step: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_max_period();
        test_lockup();
        test_timeout();
        test_back_to_back();
        test_restart_mid_count();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: got %0d want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
